// File: rtl/if_prefetch_queue_if.sv
// Fetch-stage bundle: instruction-memory request/response, redirect and ID-side outputs.
// The perf counter outputs exist only when IF_PERF_EN is defined.
interface if_prefetch_queue_if #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32,
    parameter int DEPTH  = 4
);
    logic                   mem_req_o;
    logic [ADDR_W-1:0]      mem_addr_o;
    logic                   mem_gnt_i;
    logic                   mem_rvalid_i;
    logic [INST_W-1:0]      mem_rdata_i;
    logic                   redirect_i;
    logic [ADDR_W-1:0]      redirect_pc_i;
    logic                   id_ready_i;
    logic                   inst_valid_o;
    logic [INST_W-1:0]      inst_o;
    logic [ADDR_W-1:0]      pc_o;
    logic                   if_lock_o;
    logic [$clog2(DEPTH):0] level_o;
`ifdef IF_PERF_EN
    logic [31:0]            perf_fetch_o;
    logic [31:0]            perf_starve_o;
`endif

    modport master (
        output mem_req_o, mem_addr_o, inst_valid_o, inst_o, pc_o, if_lock_o, level_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i, redirect_i, redirect_pc_i, id_ready_i
`ifdef IF_PERF_EN
        , output perf_fetch_o, perf_starve_o
`endif
    );

    modport slave (
        input  mem_req_o, mem_addr_o, inst_valid_o, inst_o, pc_o, if_lock_o, level_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i, redirect_i, redirect_pc_i, id_ready_i
`ifdef IF_PERF_EN
        , input perf_fetch_o, perf_starve_o
`endif
    );
endinterface

// File: rtl/if_prefetch_queue.sv
// Instruction fetch with an in-order prefetch queue (DEPTH entries); optional perf counters via IF_PERF_EN.
// Latency: instruction visible to ID one cycle after its rvalid; no bypass path.
// Backpressure: id_ready_i low holds the head; issue stops once in-flight + queued reaches DEPTH.
module if_prefetch_queue #(
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    if_prefetch_queue_if.master fif
);
    localparam int                PTR_W   = $clog2(DEPTH);
    localparam int                LVL_W   = PTR_W + 1;
    localparam int                STEP    = INST_W / 8;
    localparam int                OFF_W   = $clog2(STEP);
    localparam logic [LVL_W-1:0]  FULL    = LVL_W'(DEPTH);
    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(STEP);

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] resp_pc;
    logic [ADDR_W-1:0] redirect_pc;
    logic [LVL_W-1:0]  outstanding;
    logic [LVL_W-1:0]  discard;
    logic [LVL_W-1:0]  level;
    logic [LVL_W:0]    in_use;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [INST_W-1:0] q_inst [DEPTH];
    logic [ADDR_W-1:0] q_pc   [DEPTH];
    logic              redirect;
    logic              req;
    logic              issue;
    logic              resp_drop;
    logic              push;
    logic              pop;
    logic              valid;

    assign redirect    = fif.redirect_i;
    assign redirect_pc = {fif.redirect_pc_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

    // Every request reserves a queue slot, so in-flight plus queued never exceeds DEPTH.
    assign in_use    = {1'b0, outstanding} + {1'b0, level};
    assign req       = rst && !redirect && (in_use < {1'b0, FULL});
    assign issue     = req && fif.mem_gnt_i;
    assign resp_drop = fif.mem_rvalid_i && (discard != '0);
    assign push      = fif.mem_rvalid_i && (discard == '0) && !redirect;
    assign valid     = (level != '0);
    assign pop       = valid && fif.id_ready_i && !redirect;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
            level       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            outstanding <= outstanding + LVL_W'(issue) - LVL_W'(fif.mem_rvalid_i);
            if (redirect) begin
                fetch_pc <= redirect_pc;
                resp_pc  <= redirect_pc;
                // Whatever returns this cycle is consumed now; everything else still in flight is stale.
                discard  <= outstanding - LVL_W'(fif.mem_rvalid_i);
                level    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
            end else begin
                if (issue) begin
                    fetch_pc <= fetch_pc + PC_STEP;
                end
                if (resp_drop) begin
                    discard <= discard - LVL_W'(1);
                end
                if (push) begin
                    resp_pc <= resp_pc + PC_STEP;
                    wr_ptr  <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                level <= level + LVL_W'(push) - LVL_W'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_inst[wr_ptr] <= fif.mem_rdata_i;
            q_pc[wr_ptr]   <= resp_pc;
        end
    end

    assign fif.mem_req_o    = req;
    assign fif.mem_addr_o   = fetch_pc;
    assign fif.inst_valid_o = valid;
    assign fif.inst_o       = valid ? q_inst[rd_ptr] : '0;
    assign fif.pc_o         = valid ? q_pc[rd_ptr] : '0;
    assign fif.if_lock_o    = rst && !valid && !redirect;
    assign fif.level_o      = level;

`ifdef IF_PERF_EN
    logic [31:0] perf_fetch;
    logic [31:0] perf_starve;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetch  <= '0;
            perf_starve <= '0;
        end else begin
            if (pop) begin
                perf_fetch <= perf_fetch + 32'd1;
            end
            if (fif.id_ready_i && !valid) begin
                perf_starve <= perf_starve + 32'd1;
            end
        end
    end

    assign fif.perf_fetch_o  = perf_fetch;
    assign fif.perf_starve_o = perf_starve;
`endif

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst) !(push && level == FULL));
    a_no_orphan_resp: assert property (@(posedge clk) disable iff (!rst) !(fif.mem_rvalid_i && outstanding == '0));
endmodule

// File: tb/tb_if_prefetch_queue.sv
`timescale 1ns/1ps
// Expected (pc, inst) pairs are queued at each memory grant from a plain PC-stream model and
// popped by an independent monitor whenever ID accepts an instruction.
module tb_if_prefetch_queue;
    localparam int          ADDR_W   = 32;
    localparam int          INST_W   = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    typedef struct { logic [31:0] addr; int due; } pend_t;
    typedef struct { logic [31:0] pc; logic [31:0] inst; } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    if_prefetch_queue_if #(.ADDR_W(ADDR_W), .INST_W(INST_W), .DEPTH(DEPTH)) fif ();

    if_prefetch_queue #(
        .ADDR_W(ADDR_W), .INST_W(INST_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .fif (fif)
    );

    int          n_checks  = 0;
    int          n_pass    = 0;
    int          cycle     = 0;
    int          pops      = 0;
    int          starves   = 0;
    int          gnt_pct   = 100;
    int          ready_pct = 100;
    int          rv_pct    = 100;
    int          lat       = 1;
    bit          gnt_block = 1'b0;
    pend_t       pend[$];
    exp_t        exp_q[$];
    logic [31:0] model_pc   = RESET_PC;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_addr  = 32'h0;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, want, cycle);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_req"},   32'(fif.mem_req_o),    32'd0);
        check({tag, "_addr"},  fif.mem_addr_o,        RESET_PC);
        check({tag, "_valid"}, 32'(fif.inst_valid_o), 32'd0);
        check({tag, "_inst"},  fif.inst_o,            32'd0);
        check({tag, "_pc"},    fif.pc_o,              32'd0);
        check({tag, "_lock"},  32'(fif.if_lock_o),    32'd0);
        check({tag, "_level"}, 32'(fif.level_o),      32'd0);
`ifdef IF_PERF_EN
        check({tag, "_perf_fetch"},  fif.perf_fetch_o,  32'd0);
        check({tag, "_perf_starve"}, fif.perf_starve_o, 32'd0);
`endif
    endtask

    // Memory and ID drivers: in-order responses no earlier than lat cycles after grant.
    always @(posedge clk) begin
        #1;
        cycle++;
        fif.mem_gnt_i  = !gnt_block && ($urandom_range(99) < gnt_pct);
        fif.id_ready_i = ($urandom_range(99) < ready_pct);
        if (rst && pend.size() > 0 && pend[0].due <= cycle && $urandom_range(99) < rv_pct) begin
            fif.mem_rvalid_i = 1'b1;
            fif.mem_rdata_i  = memfn(pend[0].addr);
        end else begin
            fif.mem_rvalid_i = 1'b0;
            fif.mem_rdata_i  = $urandom;
        end
    end

    // Grant bookkeeping and the reference PC stream.
    always @(negedge clk) begin
        if (!rst) begin
            pend.delete();
            exp_q.delete();
            model_pc   = RESET_PC;
            prev_stall = 1'b0;
        end else begin
            if (fif.mem_rvalid_i && pend.size() > 0) void'(pend.pop_front());
            if (fif.redirect_i) begin
                check("req_during_redirect", 32'(fif.mem_req_o), 32'd0);
                exp_q.delete();
                model_pc = fif.redirect_pc_i & 32'hFFFF_FFFC;
            end else if (fif.mem_req_o && fif.mem_gnt_i) begin
                check("fetch_addr", fif.mem_addr_o, model_pc);
                pend.push_back('{addr: fif.mem_addr_o, due: cycle + lat});
                exp_q.push_back('{pc: model_pc, inst: memfn(model_pc)});
                model_pc = model_pc + 32'd4;
            end
            if (prev_stall && !fif.redirect_i) begin
                check("stall_req_held",  32'(fif.mem_req_o), 32'd1);
                check("stall_addr_held", fif.mem_addr_o,      prev_addr);
            end
            check("valid_vs_level", 32'(fif.inst_valid_o), 32'(fif.level_o != 0));
            check("if_lock",        32'(fif.if_lock_o),    32'(!fif.inst_valid_o && !fif.redirect_i));
            check("level_bound",    32'(32'(fif.level_o) <= DEPTH), 32'd1);
            prev_stall = fif.mem_req_o && !fif.mem_gnt_i;
            prev_addr  = fif.mem_addr_o;
        end
    end

    // Monitor: every instruction accepted by ID must be the next one of the expected stream.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            pops    = 0;
            starves = 0;
        end else begin
`ifdef IF_PERF_EN
            check("perf_fetch",  fif.perf_fetch_o,  32'(pops));
            check("perf_starve", fif.perf_starve_o, 32'(starves));
`endif
            if (fif.id_ready_i && !fif.inst_valid_o) starves++;
            if (fif.inst_valid_o && fif.id_ready_i && !fif.redirect_i) begin
                pops++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL pop_unexpected: got pc 0x%0h, expected no instruction (cycle %0d)", fif.pc_o, cycle);
                end else begin
                    e = exp_q.pop_front();
                    check("pop_pc",   fif.pc_o,   e.pc);
                    check("pop_inst", fif.inst_o, e.inst);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time budget, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int t0;
        int t1;
        bit found;
        fif.redirect_i    = 1'b0;
        fif.redirect_pc_i = 32'h0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle("reset");

        // Streaming: gnt=1, latency 1, ID always ready.
        @(posedge clk); #3; rst = 1'b1;
        t0 = -1; t1 = -1;
        for (int i = 0; i < 20 && t0 < 0; i++) begin
            @(negedge clk);
            if (fif.mem_req_o && fif.mem_gnt_i) t0 = cycle;
        end
        for (int i = 0; i < 20 && t1 < 0; i++) begin
            @(negedge clk);
            if (fif.inst_valid_o) t1 = cycle;
        end
        check("first_fetch_latency", 32'(t1 - t0), 32'd2);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("stream_no_gap", 32'(fif.inst_valid_o), 32'd1);
        end

        // ID stalls: queue fills, issue stops, then drains in order.
        ready_pct = 0;
        repeat (10) @(negedge clk);
        check("stall_level_full",  32'(fif.level_o),   32'(DEPTH));
        check("stall_req_dropped", 32'(fif.mem_req_o), 32'd0);
        ready_pct = 100;
        repeat (4) @(negedge clk);
        check("refetch_resumes", 32'(fif.mem_req_o), 32'd1);

        // Redirect with several responses in flight at latency 3.
        lat = 3;
        repeat (12) @(negedge clk);
        @(posedge clk); #3; fif.redirect_i = 1'b1; fif.redirect_pc_i = 32'h100;
        @(posedge clk); #3; fif.redirect_i = 1'b0;
        @(negedge clk);
        check("gap_empty", 32'(fif.inst_valid_o), 32'd0);
        check("gap_lock",  32'(fif.if_lock_o),    32'd1);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (fif.inst_valid_o) found = 1'b1;
            else @(negedge clk);
        end
        check("redirect_first_pc",   fif.pc_o,   32'h100);
        check("redirect_first_inst", fif.inst_o, memfn(32'h100));

        // Grant withheld: address must hold, queue drains, lock rises.
        lat = 1;
        gnt_block = 1'b1;
        repeat (8) @(negedge clk);
        check("gnt_low_lock",  32'(fif.if_lock_o), 32'd1);
        check("gnt_low_level", 32'(fif.level_o),   32'd0);
        check("gnt_low_req",   32'(fif.mem_req_o), 32'd1);
        gnt_block = 1'b0;

        // Redirect coinciding with a pop and an rvalid (unaligned target).
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(posedge clk); #3;
            if (fif.inst_valid_o && fif.mem_rvalid_i && fif.id_ready_i) found = 1'b1;
        end
        check("collide_found", 32'(found), 32'd1);
        fif.redirect_i = 1'b1; fif.redirect_pc_i = 32'h42;
        @(posedge clk); #3; fif.redirect_i = 1'b0;
        check("collide_level", 32'(fif.level_o),      32'd0);
        check("collide_valid", 32'(fif.inst_valid_o), 32'd0);
        repeat (10) @(negedge clk);

        // Random traffic with random (often back-to-back, unaligned) redirects.
        for (int blk = 0; blk < 20; blk++) begin
            gnt_pct   = $urandom_range(100, 30);
            ready_pct = $urandom_range(100, 20);
            rv_pct    = $urandom_range(100, 40);
            lat       = $urandom_range(4, 1);
            for (int i = 0; i < 100; i++) begin
                @(posedge clk); #3;
                if ($urandom_range(99) < 4 || (fif.redirect_i && $urandom_range(1) == 1)) begin
                    fif.redirect_i    = 1'b1;
                    fif.redirect_pc_i = $urandom_range(32'hFFFF);
                end else begin
                    fif.redirect_i = 1'b0;
                end
            end
        end
        @(posedge clk); #3; fif.redirect_i = 1'b0;
        gnt_pct = 100; ready_pct = 100; rv_pct = 100;
        repeat (20) @(negedge clk);

        // Reset mid-burst: outputs clear at once, fetch restarts at RESET_PC.
        lat = 2;
        repeat (10) @(negedge clk);
        #2; rst = 1'b0;
        #1; check_idle("mid_reset");
        repeat (3) @(posedge clk);
        #3; rst = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (fif.mem_req_o && fif.mem_gnt_i) found = 1'b1;
        end
        check("restart_addr", fif.mem_addr_o, RESET_PC);
        repeat (30) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
